scan_decoder: RTL

Parametrised N-to-2^N decoder with active-low, registered one-hot outputs and an active-low enable. It adds a self-timed scan mode that steps the asserted output through every index with a programmable dwell. It sits between control logic and multiplexed loads (digit selects, row strobes, chip selects), either decoding a supplied index directly or time-multiplexing all outputs on its own.

---
 rtl/scan_decoder_pkg.sv | 17 +
 rtl/scan_decoder_onehot.sv | 19 +
 rtl/scan_decoder.sv | 103 ++++++++++
 3 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan_decoder block and its one-hot
// index decoder.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int SEL_W_MIN = 1;
    localparam int SEL_W_MAX = 5;

endpackage

// File: rtl/scan_decoder_onehot.sv
// Combinational active-low one-hot decoder with active-low enable: y_n[k] is
// low only when enabled and idx == k.
module onehot_decoder_n #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]      idx,
    input  logic                  en_n,
    output logic [(2**SEL_W)-1:0] y_n
);

    localparam int NOUT = 2 ** SEL_W;

    generate
        for (genvar gi = 0; gi < NOUT; gi++) begin : g_out
            assign y_n[gi] = en_n | (idx != SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/scan_decoder.sv
// N-to-2^N registered active-low decoder with a self-timed scan mode that
// steps the asserted output through every index, holding each dwell+1 cycles.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] y_n,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int NOUT = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NOUT - 1);

    state_t               state_reg, state_next;
    logic [DWELL_W-1:0]   cnt_reg, cnt_next;
    logic [SEL_W-1:0]     idx_reg, idx_next;
    logic [NOUT-1:0]      y_n_reg, y_n_next;
    logic                 wrap_reg, wrap_next;
    logic                 dec_en_n;

    // Next state is re-evaluated every cycle; en_n overrides mode, and any
    // mode/enable change pre-empts a pending dwell step.
    always_comb begin
        state_next = OFF;
        idx_next   = '0;
        cnt_next   = '0;
        wrap_next  = 1'b0;

        if (en_n) begin
            state_next = OFF;
        end else if (mode == MODE_SCAN) begin
            state_next = SCAN;
        end else begin
            state_next = DIRECT;
        end

        case (state_next)
            DIRECT: begin
                idx_next = sel;
            end
            SCAN: begin
                if (state_reg != SCAN) begin
                    idx_next = '0;
                    cnt_next = '0;
                end else if (cnt_reg >= dwell) begin
                    // Live compare: lowering dwell mid-hold steps immediately.
                    idx_next  = idx_reg + SEL_W'(1);
                    cnt_next  = '0;
                    wrap_next = (idx_reg == IDX_LAST);
                end else begin
                    idx_next = idx_reg;
                    cnt_next = cnt_reg + DWELL_W'(1);
                end
            end
            default: begin
                idx_next = '0;
                cnt_next = '0;
            end
        endcase
    end

    assign dec_en_n = (state_next == OFF);

    // Decoding the next index lets y_n come straight from a flop while still
    // tracking idx in the same cycle.
    onehot_decoder_n #(
        .SEL_W (SEL_W)
    ) u_dec (
        .idx  (idx_next),
        .en_n (dec_en_n),
        .y_n  (y_n_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= OFF;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            y_n_reg   <= '1;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            y_n_reg   <= y_n_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign y_n  = y_n_reg;
    assign idx  = idx_reg;
    assign wrap = wrap_reg;

endmodule
